// File: rtl/tile_image_loader_pkg.sv
// Shared constants and FSM state encoding for the tile image loader and its tile RAMs.
package tile_image_loader_pkg;

    localparam int unsigned TILE_W         = 128;
    localparam int unsigned TILE_H         = 128;
    localparam int unsigned TILE_ADDR_W    = 14;
    localparam int unsigned TILE_IDX_W     = 4;
    localparam int unsigned TILE_PIX_W     = 12;
    localparam int unsigned TILE_NUM       = 10;
    localparam logic [7:0]  TILE_SYNC_BYTE = 8'hA5;

    typedef logic [2:0] tile_ld_state_t;

    localparam tile_ld_state_t ST_IDLE   = 3'd0;
    localparam tile_ld_state_t ST_TILE   = 3'd1;
    localparam tile_ld_state_t ST_PIX_HI = 3'd2;
    localparam tile_ld_state_t ST_PIX_LO = 3'd3;
    localparam tile_ld_state_t ST_DONE   = 3'd4;

    // Linear pixel address y*128 + x as used by the draw stage.
    function automatic logic [TILE_ADDR_W-1:0] tile_pixel_addr(input logic [6:0] x,
                                                                input logic [6:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tile_image_loader_if.sv
// Byte-stream handshake plus tile RAM write bus; master is the byte source, slave is the loader.
interface tile_image_loader_if;
    import tile_image_loader_pkg::*;

    logic [7:0]             s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   wr_en;
    logic [TILE_IDX_W-1:0]  wr_tile;
    logic [TILE_ADDR_W-1:0] wr_addr;
    logic [TILE_PIX_W-1:0]  wr_data;

    modport master (
        output s_data, s_valid,
        input  s_ready, wr_en, wr_tile, wr_addr, wr_data
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wr_en, wr_tile, wr_addr, wr_data
    );

endinterface

// File: rtl/tile_image_loader_tile_dpram.sv
// Simple dual-port tile RAM: write port fed by the loader, registered read port for the draw stage.
module tile_dpram #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_image_loader.sv
// Parses {SYNC, tile, big-endian pixel pairs...} frames into registered tile RAM write strobes.
// Optional TILE_LOADER_VBLANK_WR_EN: pixel bytes are only accepted while vblnk is high.
module tile_image_loader
    import tile_image_loader_pkg::*;
#(
    parameter int unsigned NUM_TILES   = TILE_NUM,
    parameter int unsigned TILE_PIXELS = TILE_W * TILE_H,
    parameter logic [7:0]  SYNC_BYTE   = TILE_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    tile_image_loader_if.slave bus,
    input  logic               vblnk,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    tile_ld_state_t         state_q, state_d;
    logic [TILE_IDX_W-1:0]  tile_q, tile_d;
    logic [3:0]             red_q, red_d;
    logic [14:0]            pix_cnt_q, pix_cnt_d;
    logic [TO_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic                   s_ready_q, s_ready_d;
    logic                   wr_en_q, wr_en_d;
    logic [TILE_IDX_W-1:0]  wr_tile_q, wr_tile_d;
    logic [TILE_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [TILE_PIX_W-1:0]  wr_data_q, wr_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic pix_state, ready_gate, idle_count_en, s_ready, accept;

    assign pix_state = (state_q == ST_PIX_HI) || (state_q == ST_PIX_LO);

`ifdef TILE_LOADER_VBLANK_WR_EN
    // Pixel bytes stall outside vertical blank; the idle timer stalls with them.
    assign ready_gate    = !pix_state || vblnk;
    assign idle_count_en = ready_gate;
`else
    logic unused_vblnk;
    assign unused_vblnk  = vblnk;
    assign ready_gate    = 1'b1;
    assign idle_count_en = 1'b1;
`endif

    assign s_ready = s_ready_q && ready_gate;
    assign accept  = bus.s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        tile_d     = tile_q;
        red_d      = red_q;
        pix_cnt_d  = pix_cnt_q;
        idle_cnt_d = idle_cnt_q;
        wr_en_d    = 1'b0;
        wr_tile_d  = wr_tile_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (accept && (bus.s_data == SYNC_BYTE)) begin
                    state_d = ST_TILE;
                end
            end
            ST_TILE: begin
                if (accept) begin
                    if (32'(bus.s_data) < NUM_TILES) begin
                        tile_d    = bus.s_data[TILE_IDX_W-1:0];
                        pix_cnt_d = '0;
                        state_d   = ST_PIX_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PIX_HI: begin
                if (accept) begin
                    red_d   = bus.s_data[3:0];
                    state_d = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_tile_d = tile_q;
                    wr_addr_d = pix_cnt_q[TILE_ADDR_W-1:0];
                    wr_data_d = {red_q, bus.s_data};
                    pix_cnt_d = pix_cnt_q + 15'd1;
                    if (pix_cnt_q == 15'(TILE_PIXELS - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PIX_HI;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte always wins over an expiring idle timer.
        if ((state_q == ST_TILE) || pix_state) begin
            if (accept) begin
                idle_cnt_d = '0;
            end else if (idle_count_en) begin
                if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    idle_cnt_d = '0;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
            end
        end

        s_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tile_q     <= '0;
            red_q      <= '0;
            pix_cnt_q  <= '0;
            idle_cnt_q <= '0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_tile_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            red_q      <= red_d;
            pix_cnt_q  <= pix_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            s_ready_q  <= s_ready_d;
            wr_en_q    <= wr_en_d;
            wr_tile_q  <= wr_tile_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_tile = wr_tile_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_tile_image_loader.sv
// Bench for tile_image_loader: directed frames with random pixel data against an expected-write queue.
module tb_tile_image_loader;
    import tile_image_loader_pkg::*;

    localparam int unsigned NT = 10;
    localparam int unsigned TP = 16384;
    localparam int unsigned TO = 100;

    typedef struct packed {
        logic [3:0]  tile;
        logic [13:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic        busy, done, err;
    logic [13:0] raddr;
    logic [11:0] rdata [NT];

    int  tests     = 0;
    int  fails     = 0;
    int  done_seen = 0;
    int  err_seen  = 0;
    wr_t exp_q[$];

    tile_image_loader_if bus ();

    tile_image_loader #(
        .NUM_TILES  (NT),
        .TILE_PIXELS(TP),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .vblnk(vblnk),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    for (genvar g = 0; g < NT; g++) begin : g_ram
        tile_dpram #(.DEPTH(TP), .DATA_W(12)) u_ram (
            .clk    (clk),
            .we_i   (bus.wr_en && (bus.wr_tile == 4'(g))),
            .waddr_i(bus.wr_addr),
            .wdata_i(bus.wr_data),
            .raddr_i(raddr),
            .rdata_o(rdata[g])
        );
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest pixel the bench has sent.
    always @(negedge clk) begin
        wr_t e;
        if (done === 1'b1) begin
            done_seen++;
            check("done_with_wr_en", 32'(bus.wr_en), 1);
        end
        if (err === 1'b1) err_seen++;
        if (bus.wr_en === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write", 32'({bus.wr_tile, bus.wr_addr, bus.wr_data}), 32'(e));
            end
        end
    end

    task automatic gap(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("ready_wait", 32'(n), 0);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic send_px(input logic [3:0] t, input logic [13:0] a,
                           input logic [7:0] hi, input logic [7:0] lo, input int unsigned g);
        send(hi);
        gap(g);
        exp_q.push_back({t, a, hi[3:0], lo});
        send(lo);
    endtask

    task automatic rand_frame(input logic [3:0] t, input int unsigned npix);
        logic [7:0] hi, lo;
        send(8'hA5);
        send({4'h0, t});
        for (int unsigned i = 0; i < npix; i++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            if (i == 1) hi = 8'hA5;
            send_px(t, 14'(i), hi, lo, $urandom_range(0, 3));
            gap($urandom_range(0, 3));
        end
    endtask

    task automatic stall_timeout();
        int e0;
        e0 = err_seen;
        repeat (TO + 4) @(negedge clk);
        check("timeout_err", 32'(err_seen - e0), 1);
        check("idle_after_timeout", 32'(busy), 0);
    endtask

    initial begin
        int e0;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        raddr       = '0;
`ifdef TILE_LOADER_VBLANK_WR_EN
        vblnk = 1'b1;
`else
        vblnk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({bus.s_ready, bus.wr_en, busy, done, err}), 0);
        check("reset_bus", 32'({bus.wr_tile, bus.wr_addr, bus.wr_data}), 0);
        rst = 1'b0;

        // Full tile 3, all pixels 0xF00, back to back
        send(8'hA5);
        send(8'h03);
        for (int unsigned i = 0; i < TP - 1; i++) send_px(4'd3, 14'(i), 8'h0F, 8'h00, 0);
        send(8'h0F);
        exp_q.push_back({4'd3, 14'(TP - 1), 12'hF00});
        send(8'h00);
        @(negedge clk);
        check("done_pulse", 32'(done), 1);
        check("last_addr", 32'(bus.wr_addr), TP - 1);
        check("done_ready_low", 32'(bus.s_ready), 0);
        check("done_busy", 32'(busy), 1);
        @(negedge clk);
        check("after_done", 32'({done, busy, bus.s_ready}), 32'b001);
        check("done_count", 32'(done_seen), 1);
        check("full_drained", 32'(exp_q.size()), 0);
        for (int k = 0; k < 3; k++) begin
            raddr = (k == 0) ? 14'(TP - 1) : 14'($urandom);
            gap(2);
            check("readback_tile3", 32'(rdata[3]), 32'h0F00);
        end

        // Garbage before sync, one pixel, then stall
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        exp_q.push_back({4'd2, 14'd0, 12'h123});
        send(8'h23);
        @(negedge clk);
        check("lat_wr_en", 32'(bus.wr_en), 1);
        check("lat_data", 32'(bus.wr_data), 32'h123);
        check("lat_addr", 32'(bus.wr_addr), 0);
        check("lat_tile", 32'(bus.wr_tile), 2);
        stall_timeout();

        // Bad tile index
        send(8'hA5);
        send(8'h0A);
        @(negedge clk);
        check("bad_idx_err", 32'(err), 1);
        check("bad_idx_busy", 32'(busy), 0);
        @(negedge clk);
        check("bad_idx_err_clear", 32'(err), 0);
        send(8'hA5);
        send(8'($urandom_range(NT, 255)));
        @(negedge clk);
        check("bad_idx_rand_err", 32'(err), 1);
        rand_frame(4'd0, 4);
        stall_timeout();

        // Exact timeout cycle with a partial pixel pending
        send(8'hA5);
        send(8'h01);
        send(8'h0F);
        for (int unsigned k = 0; k <= TO; k++) begin
            @(negedge clk);
            check("timeout_cycle", 32'(err), 32'(k == TO));
        end
        check("timeout_idle", 32'(busy), 0);
        rand_frame(4'd1, 3);
        stall_timeout();

        // Reset in the middle of a frame
        rand_frame(4'd5, 50);
        send(8'h3C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", 32'({bus.s_ready, bus.wr_en, busy, done, err}), 0);
        check("midrst_bus", 32'({bus.wr_tile, bus.wr_addr, bus.wr_data}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_quiet", 32'({bus.wr_en, busy}), 0);
        rand_frame(4'd5, 3);
        stall_timeout();

        // Random frames on random tiles
        for (int r = 0; r < 4; r++) begin
            rand_frame(4'($urandom_range(0, NT - 1)), $urandom_range(2, 20));
            stall_timeout();
        end

`ifdef TILE_LOADER_VBLANK_WR_EN
        send(8'hA5);
        send(8'h06);
        vblnk = 1'b0;
        @(negedge clk);
        check("vblank_stall_ready", 32'(bus.s_ready), 0);
        e0          = err_seen;
        bus.s_data  = 8'h07;
        bus.s_valid = 1'b1;
        repeat (TO + 20) @(negedge clk);
        check("vblank_no_timeout", 32'(err_seen - e0), 0);
        check("vblank_still_busy", 32'({busy, bus.s_ready}), 32'b10);
        bus.s_valid = 1'b0;
        vblnk       = 1'b1;
        send_px(4'd6, 14'd0, 8'h07, 8'h9C, 0);
        send_px(4'd6, 14'd1, 8'($urandom), 8'($urandom), 1);
        stall_timeout();
`else
        send(8'hA5);
        send(8'h06);
        @(negedge clk);
        check("vblnk_ignored_ready", 32'(bus.s_ready), 1);
        send_px(4'd6, 14'd0, 8'h07, 8'h9C, 0);
        send_px(4'd6, 14'd1, 8'($urandom), 8'($urandom), 1);
        stall_timeout();
`endif

        raddr = 14'd0;
        gap(2);
        check("readback_tile6", 32'(rdata[6]), 32'h79C);
        check("drained", 32'(exp_q.size()), 0);
        check("done_total", 32'(done_seen), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
